pwm_dac_fetch: RTL and testbench
================================

# pwm_dac_fetch

PWM DAC front end that consumes samples from the NCO over its `next_sample`/`code` pull interface. Pulses `next_sample` once per PWM window, captures the returned code one cycle later, and double-buffers it so each window plays one stable duty cycle. Sits between the NCO and the audio PWM pin; it is the sample consumer the NCO bench models with its fetch thread.

## Interface
- `CODE_WIDTH`, default 10: sample width W; PWM window length N = 2^W cycles; legal range 3..16.
- `clk`  input  1  system clock (125 MHz).
- `rst_n`  input  1  synchronous, active-low reset.
- `en`  input  1  run enable; low holds the block idle with PWM low.
- `code`  input  W  NCO sample; valid the cycle after a `next_sample` pulse.
- `next_sample`  output  1  single-cycle pull strobe to the NCO.
- `pwm`  output  1  PWM output.
- `active_code`  output  W  code currently being played.
- `sample_count`  output  32  samples fetched; present only with `DAC_SAMPLE_COUNT_EN`.

## Operation
- States: IDLE, PRIME_REQ, PRIME_CAP, RUN. Window counter `cnt` is W bits; the `pending` register is W bits.
- IDLE: `cnt`=0, `next_sample`=0, `pwm`=0. `en`=1 moves to PRIME_REQ.
- PRIME_REQ: `next_sample`=1 for this one cycle. Go to PRIME_CAP.
- PRIME_CAP: on the edge leaving this state, `active_code` takes `code` and `cnt` is set to 0. Go to RUN.
- RUN: `cnt` increments every cycle and wraps from N-1 to 0.
  - `next_sample`=1 exactly when `cnt`==N-3.
  - On the edge leaving `cnt`==N-2, `pending` takes `code`.
  - On the wrap edge (N-1 to 0), `active_code` takes `pending`.
- Each window fetches exactly one sample.
- `pwm` = (state==RUN) && (`cnt` < `active_code`). It is decoded from registers only, with no input-to-output path.
  - Code 0 gives a constant low.
  - Code N-1 gives high for N-1 of N cycles.
- `en` is sampled every edge. If `en`=0 in any state, the next state is IDLE and `cnt`=0. `active_code` and `pending` hold.
  - A request already issued but not yet captured is dropped. The NCO has still advanced.
- Re-raising `en` always re-primes through PRIME_REQ/PRIME_CAP; no stale pending code is played.
- `next_sample` is never high on two consecutive cycles.

## Timing
- Reset (rst_n=0 at an edge) takes effect at that edge. This applies mid-window and mid-prime.
- Reset values: state=IDLE, `cnt`=0, `pending`=0, `active_code`=0, `next_sample`=0, `pwm`=0, `sample_count`=0.
- Latency from `en` rising (sampled at edge E0):
  - `next_sample` is high in the cycle after E0.
  - `active_code` is valid and the first RUN cycle (`cnt`=0) starts two cycles after E0.
- Steady-state pull period is exactly N cycles.
- Sample-to-play latency: a code captured at `cnt`=N-2 is played from the following `cnt`=0, i.e. 2 cycles later. It stays active for N cycles.
- The NCO contract is that `code` updates on the edge where `next_sample`=1. This block never samples `code` in the cycle `next_sample` is high.

## Configuration
- `DAC_SAMPLE_COUNT_EN` defined:
  - `sample_count` port exists.
  - It increments by 1 on every edge where `next_sample`=1, covering both prime and RUN requests.
  - It wraps modulo 2^32 and is cleared only by reset.
- Not defined: no port and no counter logic. All other behaviour is identical.

## Structure
- Shared package `dac_pkg`:
  - state enum (IDLE, PRIME_REQ, PRIME_CAP, RUN);
  - default `CODE_WIDTH`=10;
  - fetch offset constants REQ_OFFSET=3 and CAP_OFFSET=2, expressed as N minus offset.
- Single flat module. No sub-module is warranted: counter, FSM and comparator are each a few lines.

## Test plan
- Reset and idle: rst_n=0 for 3 cycles, then rst_n=1 with en=0 for 100 cycles -> pwm=0, next_sample=0, active_code=0 throughout.
- Prime and first window: behavioural NCO model returns 512 on the first pull. Raise en -> next_sample high in the cycle after; active_code=512 two cycles after en; pwm high for exactly 512 of the first 1024 RUN cycles.
- Steady pull: model returns 512, 524, 537, 636. Over 4 windows -> next_sample pulses exactly 1024 cycles apart, each at cnt=1021; active_code steps through the values at each wrap; high-time equals the code per window.
- Boundary codes, W=4: codes 0 then 15 -> window 1 pwm all low, window 2 high for 15 of 16 cycles; a pull occurs every 16 cycles at cnt=13.
- Disable and reset mid-operation:
  - en=0 at cnt=1022, after the pull and before capture -> IDLE next edge, pwm=0, active_code unchanged.
  - en=1 again -> fresh prime pull.
  - Repeat with rst_n=0 at cnt=500 -> all reset values at that edge.
- With `DAC_SAMPLE_COUNT_EN`: prime plus 10 windows -> sample_count=11; after reset, 0.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the PWM DAC sample fetcher: FSM states, default
// sample width, and where in the PWM window the NCO pull and capture happen.
// Latency: n/a (declarations only). Backpressure: n/a.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRIME_REQ = 2'd1,
    PRIME_CAP = 2'd2,
    RUN       = 2'd3
  } dac_state_t;

  localparam int CODE_WIDTH_DEF = 10;

  // Window positions are counted back from the window length N = 2^W:
  // the pull strobe fires at N-REQ_OFFSET, the returned code is captured
  // on the edge leaving N-CAP_OFFSET.
  localparam int REQ_OFFSET = 3;
  localparam int CAP_OFFSET = 2;

  function automatic int win_pos(input int width, input int offset);
    return (1 << width) - offset;
  endfunction

endpackage

// File: rtl/pwm_dac_fetch.sv
// PWM DAC front end: pulls one NCO sample per 2^W-cycle window and plays it as one stable duty cycle.
// Latency: en sampled high at E0 -> next_sample in cycle E0+1, first RUN cycle with new active_code at E0+2; capture-to-play 2 cycles.
// Backpressure: none; the NCO must answer every next_sample strobe on the following cycle; dropping en abandons any uncaptured pull.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   en           run enable; low forces IDLE with pwm low
//   code         NCO sample, valid the cycle after next_sample
//   next_sample  single-cycle pull strobe to the NCO
//   pwm          PWM output, high while window counter < active_code
//   active_code  code being played in the current window
//   sample_count number of pull strobes issued (only with DAC_SAMPLE_COUNT_EN)
//
// Optional feature macro: DAC_SAMPLE_COUNT_EN adds the sample_count port and counter.
module pwm_dac_fetch
  import dac_pkg::*;
#(
  parameter int CODE_WIDTH = CODE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  next_sample,
  output logic                  pwm,
  output logic [CODE_WIDTH-1:0] active_code
`ifdef DAC_SAMPLE_COUNT_EN
  ,
  output logic [31:0]           sample_count
`endif
);

  localparam logic [CODE_WIDTH-1:0] L_CNT_REQ  = CODE_WIDTH'(win_pos(CODE_WIDTH, REQ_OFFSET));
  localparam logic [CODE_WIDTH-1:0] L_CNT_CAP  = CODE_WIDTH'(win_pos(CODE_WIDTH, CAP_OFFSET));
  localparam logic [CODE_WIDTH-1:0] L_CNT_LAST = CODE_WIDTH'(win_pos(CODE_WIDTH, 1));
  localparam logic [CODE_WIDTH-1:0] L_ONE      = {{(CODE_WIDTH-1){1'b0}}, 1'b1};

  dac_state_t            r_state;
  logic [CODE_WIDTH-1:0] r_cnt;
  logic [CODE_WIDTH-1:0] r_pending;
  logic [CODE_WIDTH-1:0] r_active;

  dac_state_t            w_state_nxt;
  logic [CODE_WIDTH-1:0] w_cnt_nxt;
  logic [CODE_WIDTH-1:0] w_pending_nxt;
  logic [CODE_WIDTH-1:0] w_active_nxt;
  logic                  w_next_sample;
  logic                  w_pwm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= '0;
      r_active  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_active  <= w_active_nxt;
    end
  end

  // Outputs depend only on registered state, so there is no en/code to
  // pwm/next_sample combinational path.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_active_nxt  = r_active;
    w_next_sample = 1'b0;
    w_pwm         = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (en) w_state_nxt = PRIME_REQ;
      end
      PRIME_REQ: begin
        w_next_sample = 1'b1;
        w_state_nxt   = PRIME_CAP;
      end
      PRIME_CAP: begin
        // The NCO answered on the previous edge; load it straight into play.
        w_active_nxt = code;
        w_cnt_nxt    = '0;
        w_state_nxt  = RUN;
      end
      RUN: begin
        w_next_sample = (r_cnt == L_CNT_REQ);
        w_pwm         = (r_cnt < r_active);
        w_cnt_nxt     = r_cnt + L_ONE;   // natural wrap N-1 -> 0
        if (r_cnt == L_CNT_CAP)  w_pending_nxt = code;
        if (r_cnt == L_CNT_LAST) w_active_nxt  = r_pending;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Disable wins over everything: an outstanding pull is simply abandoned
    // and the played/pending codes are frozen until the next prime.
    if (!en) begin
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_pending_nxt = r_pending;
      w_active_nxt  = r_active;
    end
  end

  assign next_sample = w_next_sample;
  assign pwm         = w_pwm;
  assign active_code = r_active;

`ifdef DAC_SAMPLE_COUNT_EN
  logic [31:0] r_sample_count;

  // Counts every strobe actually issued, including ones later dropped by
  // a disable, since the NCO advances on each of them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sample_count <= '0;
    end else if (w_next_sample) begin
      r_sample_count <= r_sample_count + 32'd1;
    end
  end

  assign sample_count = r_sample_count;
`endif

endmodule

// File: tb/tb_pwm_dac_fetch.sv
// Bench for pwm_dac_fetch: a W=10 and a W=4 instance, each fed by a table-driven NCO model.
// Latency: n/a. Backpressure: n/a (the NCO model always answers on the cycle after a pull).
// With DAC_SAMPLE_COUNT_EN defined the sample_count port is connected and checked.
module tb_pwm_dac_fetch;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  // W=10 instance
  logic       rst10_n, en10, ns10, pwm10;
  logic [9:0] code10, act10;
  // W=4 instance
  logic       rst4_n, en4, ns4, pwm4;
  logic [3:0] code4, act4;
`ifdef DAC_SAMPLE_COUNT_EN
  logic [31:0] sc10, sc4;
`endif

  pwm_dac_fetch #(.CODE_WIDTH(10)) u_dut10 (
    .clk         (clk),
    .rst_n       (rst10_n),
    .en          (en10),
    .code        (code10),
    .next_sample (ns10),
    .pwm         (pwm10),
    .active_code (act10)
`ifdef DAC_SAMPLE_COUNT_EN
    ,
    .sample_count(sc10)
`endif
  );

  pwm_dac_fetch #(.CODE_WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst4_n),
    .en          (en4),
    .code        (code4),
    .next_sample (ns4),
    .pwm         (pwm4),
    .active_code (act4)
`ifdef DAC_SAMPLE_COUNT_EN
    ,
    .sample_count(sc4)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int consec = 0;
  int last_pull [2];

  always @(posedge clk) cyc <= cyc + 1;

  // NCO models: advance on every edge where the strobe is high.
  logic [9:0] tbl10 [0:15];
  logic [3:0] tbl4  [0:15];
  int idx10 = 0;
  int idx4  = 0;

  always @(posedge clk) begin
    if (ns10) begin
      code10 <= (idx10 < 16) ? tbl10[idx10] : 10'd0;
      idx10  <= idx10 + 1;
    end
    if (ns4) begin
      code4 <= (idx4 < 16) ? tbl4[idx4] : 4'd0;
      idx4  <= idx4 + 1;
    end
  end

  // Back-to-back strobes are never legal.
  logic prev10 = 1'b0;
  logic prev4  = 1'b0;
  always @(negedge clk) begin
    if (ns10 && prev10) consec++;
    if (ns4 && prev4) consec++;
    prev10 = ns10;
    prev4  = ns4;
  end

  typedef struct {
    int          sel;        // 0: W=10 instance, 1: W=4 instance
    logic [15:0] exp_act;    // code played throughout the window
    int          exp_high;   // pwm-high cycles in the window
    int          exp_off;    // cnt at which the pull strobe appears
    int          exp_space;  // cycles since the previous strobe
  } win_t;

  win_t wins [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, a, e);
    end
  endtask

  function automatic logic [15:0] g_act(input int s);
    return (s != 0) ? {12'd0, act4} : {6'd0, act10};
  endfunction
  function automatic logic g_ns(input int s);
    return (s != 0) ? ns4 : ns10;
  endfunction
  function automatic logic g_pwm(input int s);
    return (s != 0) ? pwm4 : pwm10;
  endfunction

  task automatic set_en(input int s, input logic v);
    if (s != 0) en4 = v;
    else        en10 = v;
  endtask

  task automatic prime(input int s, input logic [15:0] exp);
    set_en(s, 1'b1);
    tick();
    chk("prime_pull", {31'd0, g_ns(s)}, 32'd1);
    last_pull[s] = cyc;
    tick();
    chk("prime_cap_no_pull", {31'd0, g_ns(s)}, 32'd0);
    tick();
    chk("prime_active", {16'd0, g_act(s)}, {16'd0, exp});
  endtask

  task automatic run_window(input win_t w);
    int n, high, pulls, off, bad, space;
    n = (w.sel != 0) ? 16 : 1024;
    high = 0; pulls = 0; off = -1; bad = 0; space = -1;
    for (int k = 0; k < n; k++) begin
      if (g_act(w.sel) !== w.exp_act) bad++;
      if (g_pwm(w.sel)) high++;
      if (g_ns(w.sel)) begin
        pulls++;
        off   = k;
        space = cyc - last_pull[w.sel];
        last_pull[w.sel] = cyc;
      end
      tick();
    end
    chk("win_active_unstable", bad, 0);
    chk("win_high_time", high, w.exp_high);
    chk("win_pull_count", pulls, 1);
    chk("win_pull_cnt", off, w.exp_off);
    chk("win_pull_spacing", space, w.exp_space);
  endtask

  initial begin
    int bad_idle;

    tbl10[0] = 10'd512; tbl10[1] = 10'd524; tbl10[2] = 10'd537; tbl10[3] = 10'd636;
    tbl10[4] = 10'd100; tbl10[5] = 10'd200; tbl10[6] = 10'd300; tbl10[7] = 10'd400;
    tbl10[8] = 10'd500;
    for (int i = 9; i < 16; i++) tbl10[i] = 10'd0;
    tbl4[0] = 4'd0; tbl4[1] = 4'd15; tbl4[2] = 4'd1; tbl4[3] = 4'd8; tbl4[4] = 4'd14;
    tbl4[5] = 4'd3;
    for (int i = 6; i < 16; i++) tbl4[i] = 4'd0;

    //         sel  act  high  off  spacing
    wins[0] = '{0, 512, 512, 1021, 1023};
    wins[1] = '{0, 524, 524, 1021, 1024};
    wins[2] = '{0, 537, 537, 1021, 1024};
    wins[3] = '{0, 636, 636, 1021, 1024};
    wins[4] = '{0, 300, 300, 1021, 1023};
    wins[5] = '{1,   0,   0,   13,   15};
    wins[6] = '{1,  15,  15,   13,   16};
    wins[7] = '{1,   1,   1,   13,   16};
    wins[8] = '{1,   8,   8,   13,   16};
    wins[9] = '{1,  14,  14,   13,   16};

    rst10_n = 1'b0; rst4_n = 1'b0; en10 = 1'b0; en4 = 1'b0;
    code10 = '0; code4 = '0;
    last_pull[0] = 0; last_pull[1] = 0;

    // Reset, then a long idle stretch.
    for (int i = 0; i < 3; i++) tick();
    chk("rst_pwm10", {31'd0, pwm10}, 32'd0);
    chk("rst_ns10", {31'd0, ns10}, 32'd0);
    chk("rst_act10", {22'd0, act10}, 32'd0);
    chk("rst_act4", {28'd0, act4}, 32'd0);
`ifdef DAC_SAMPLE_COUNT_EN
    chk("rst_count10", sc10, 32'd0);
`endif
    rst10_n = 1'b1; rst4_n = 1'b1;
    bad_idle = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pwm10 || ns10 || act10 != 0 || pwm4 || ns4 || act4 != 0) bad_idle++;
    end
    chk("idle_outputs", bad_idle, 0);

    // Prime and four steady windows on the W=10 instance.
    prime(0, 16'd512);
    for (int i = 0; i < 4; i++) run_window(wins[i]);
    chk("win5_active", {22'd0, act10}, 32'd100);

    // Disable after the pull at cnt=1021 but before the capture at 1022.
    for (int i = 0; i < 1021; i++) tick();
    chk("pre_disable_pull", {31'd0, ns10}, 32'd1);
    tick();
    en10 = 1'b0;
    tick();
    chk("disable_pwm", {31'd0, pwm10}, 32'd0);
    chk("disable_ns", {31'd0, ns10}, 32'd0);
    chk("disable_act_hold", {22'd0, act10}, 32'd100);
    tick();
    chk("disable_still_idle", {31'd0, pwm10 | ns10}, 32'd0);

    // Re-prime fetches a fresh code (200 was pulled and dropped).
    prime(0, 16'd300);
    run_window(wins[4]);

    // Reset in the middle of a window.
    for (int i = 0; i < 500; i++) tick();
    chk("pre_reset_act", {22'd0, act10}, 32'd400);
    rst10_n = 1'b0;
    tick();
    chk("midreset_act", {22'd0, act10}, 32'd0);
    chk("midreset_pwm", {31'd0, pwm10}, 32'd0);
    chk("midreset_ns", {31'd0, ns10}, 32'd0);
`ifdef DAC_SAMPLE_COUNT_EN
    chk("midreset_count10", sc10, 32'd0);
`endif
    rst10_n = 1'b1;
    prime(0, 16'd500);
    en10 = 1'b0;
    tick();

    // Boundary codes on the W=4 instance.
    prime(1, 16'd0);
    for (int i = 5; i < 10; i++) run_window(wins[i]);

`ifdef DAC_SAMPLE_COUNT_EN
    rst4_n = 1'b0;
    tick();
    chk("count4_after_reset", sc4, 32'd0);
    rst4_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("count4_prime", sc4, 32'd1);
    for (int i = 0; i < 160; i++) tick();
    chk("count4_10win", sc4, 32'd11);
    rst4_n = 1'b0;
    tick();
    chk("count4_cleared", sc4, 32'd0);
    rst4_n = 1'b1;
`endif
    en4 = 1'b0;
    tick();
    tick();

    chk("no_consecutive_pulls", consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
